// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning channel multiplexer.
// Mode encodings and width arithmetic used across the mux slice.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v > 1) ? v : 1;
  endfunction

endpackage

// File: rtl/mux_nw.sv
// Combinational CHANNELS:1 selector of WIDTH-bit words.
// Out-of-range selects produce zero; callers gate them via legality.
module mux_nw
  import mux_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int SELW     = max1(clog2(CHANNELS))
) (
  output logic [WIDTH-1:0]          y,
  input  logic [SELW-1:0]           s,
  input  logic [CHANNELS*WIDTH-1:0] i
);

  always_comb begin
    y = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (s == SELW'(k)) y = i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel mux with manual select and auto-scan modes.
// Auto mode holds each channel for DWELL enabled cycles, then advances.
module mux_scan
  import mux_pkg::*;
#(
  parameter int  WIDTH    = 10,
  parameter int  CHANNELS = 4,
  parameter int  DWELL    = 1000,
  localparam int SELW     = max1(clog2(CHANNELS))
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           s,
  input  logic [CHANNELS*WIDTH-1:0] i,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      valid
);

  localparam int CNTW = max1(clog2(DWELL));
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0] r_y;
  logic [SELW-1:0]  r_ch;
  logic             r_valid;
  logic [SELW-1:0]  r_idx;
  logic [CNTW-1:0]  r_cnt;

  logic [WIDTH-1:0] w_y_nxt;
  logic [SELW-1:0]  w_ch_nxt;
  logic             w_valid_nxt;
  logic [SELW-1:0]  w_idx_nxt;
  logic [CNTW-1:0]  w_cnt_nxt;

  logic             w_auto;
  logic             w_s_ok;
  logic [SELW-1:0]  w_sel;
  logic [WIDTH-1:0] w_data;
  logic [SELW-1:0]  w_idx_inc;

  assign w_auto = (mode == MODE_AUTO);
  assign w_s_ok = (32'(s) < 32'(CHANNELS));
  assign w_sel  = w_auto ? r_idx : s;

  // Explicit wrap so non-power-of-two channel counts never overflow.
  assign w_idx_inc = (r_idx == IDX_LAST) ? '0 : r_idx + SELW'(1);

  mux_nw #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SELW     (SELW)
  ) u_sel (
    .y (w_data),
    .s (w_sel),
    .i (i)
  );

  always_comb begin
    w_y_nxt     = r_y;
    w_ch_nxt    = r_ch;
    w_valid_nxt = r_valid;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    if (en) begin
      if (w_auto) begin
        w_y_nxt     = w_data;
        w_ch_nxt    = r_idx;
        w_valid_nxt = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = w_idx_inc;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end else if (w_s_ok) begin
        w_y_nxt     = w_data;
        w_ch_nxt    = s;
        w_valid_nxt = 1'b1;
        w_idx_nxt   = s;
        w_cnt_nxt   = '0;
      end else begin
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_y     <= w_y_nxt;
      r_ch    <= w_ch_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign y     = r_y;
  assign ch    = r_ch;
  assign valid = r_valid;

endmodule
